// File: rtl/global_defs.sv
// Global sizing constants shared by the MPU blocks: matrix limits and
// address/index widths.
package global_defs;
    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_BITS = 2;
    localparam int MEM_ADDR_BITS   = 12;
endpackage

// File: rtl/mpu_data_types.sv
// Shared MPU data types: IEEE-754 single-precision word and the load
// sequencer state encoding.
package mpu_data_types;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_sp;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE,
        ERR
    } ld_state_e;
endpackage

// File: rtl/mpu_load_sequencer.sv
// Streams an m x n row-major matrix from memory into a matrix register,
// one element at a time: read, wait for data, write, repeat.
module mpu_load_sequencer
    import global_defs::*;
    import mpu_data_types::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_req_in,
    input  logic [MATRIX_REG_BITS:0]   ld_reg_addr_in,
    input  logic [MBITS:0]             ld_m_in,
    input  logic [NBITS:0]             ld_n_in,
    input  logic [MEM_ADDR_BITS-1:0]   ld_mem_base_in,
    output logic                       ld_busy_out,
    output logic                       ld_done_out,
    output logic                       ld_err_out,
    output logic                       mem_rd_req_out,
    output logic [MEM_ADDR_BITS-1:0]   mem_rd_addr_out,
    input  logic                       mem_rd_valid_in,
    input  float_sp                    mem_rd_data_in,
    input  logic                       load_ready_in,
    output logic                       reg_load_req_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output float_sp                    reg_load_element_out
);

    localparam logic [MBITS:0]         M_LIM    = M[MBITS:0];
    localparam logic [NBITS:0]         N_LIM    = N[NBITS:0];
    localparam logic [MBITS:0]         I_ONE    = 1;
    localparam logic [NBITS:0]         J_ONE    = 1;
    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = 1;

    ld_state_e                  state_q, state_d;
    logic [MATRIX_REG_BITS:0]   reg_addr_q, reg_addr_d;
    logic [MBITS:0]             m_q, m_d, i_q, i_d;
    logic [NBITS:0]             n_q, n_d, j_q, j_d;
    logic [MEM_ADDR_BITS-1:0]   base_q, base_d;
    logic [MEM_ADDR_BITS-1:0]   offset_q, offset_d;
    float_sp                    elem_q, elem_d;

    logic size_bad;
    logic last_elem;

    assign size_bad  = (ld_m_in == '0) || (ld_n_in == '0) ||
                       (ld_m_in > M_LIM) || (ld_n_in > N_LIM);
    assign last_elem = (i_q == m_q - I_ONE) && (j_q == n_q - J_ONE);

    always_comb begin
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        m_d        = m_q;
        n_d        = n_q;
        i_d        = i_q;
        j_d        = j_q;
        base_d     = base_q;
        offset_d   = offset_q;
        elem_d     = elem_q;

        case (state_q)
            IDLE: begin
                if (ld_req_in) begin
                    reg_addr_d = ld_reg_addr_in;
                    m_d        = ld_m_in;
                    n_d        = ld_n_in;
                    base_d     = ld_mem_base_in;
                    i_d        = '0;
                    j_d        = '0;
                    offset_d   = '0;
                    state_d    = size_bad ? ERR : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                if (mem_rd_valid_in) begin
                    elem_d  = mem_rd_data_in;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (load_ready_in) begin
                    if (last_elem) begin
                        state_d = DONE;
                    end else begin
                        // Row-major order keeps addresses contiguous, so a
                        // running offset replaces base + i*n + j.
                        offset_d = offset_q + ADDR_ONE;
                        if (j_q == n_q - J_ONE) begin
                            j_d = '0;
                            i_d = i_q + I_ONE;
                        end else begin
                            j_d = j_q + J_ONE;
                        end
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            reg_addr_q <= '0;
            m_q        <= '0;
            n_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            base_q     <= '0;
            offset_q   <= '0;
            elem_q     <= '0;
        end else begin
            state_q    <= state_d;
            reg_addr_q <= reg_addr_d;
            m_q        <= m_d;
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            base_q     <= base_d;
            offset_q   <= offset_d;
            elem_q     <= elem_d;
        end
    end

    assign ld_busy_out          = (state_q != IDLE);
    assign ld_done_out          = (state_q == DONE);
    assign ld_err_out           = (state_q == ERR);
    assign mem_rd_req_out       = (state_q == READ);
    assign mem_rd_addr_out      = base_q + offset_q;
    assign reg_load_req_out     = (state_q == WRITE);
    assign reg_load_addr_out    = reg_addr_q;
    assign reg_i_load_loc_out   = i_q;
    assign reg_j_load_loc_out   = j_q;
    assign reg_m_load_size_out  = m_q;
    assign reg_n_load_size_out  = n_q;
    assign reg_load_element_out = elem_q;

endmodule

// File: tb/tb_mpu_load_sequencer.sv
// Scoreboard bench for mpu_load_sequencer: a reference model queues the
// expected reads, writes and completions; monitors pop and compare.
module tb_mpu_load_sequencer;
    import global_defs::*;
    import mpu_data_types::*;

    localparam int MEM_SIZE = 1 << MEM_ADDR_BITS;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ld_req_in;
    logic [MATRIX_REG_BITS:0] ld_reg_addr_in;
    logic [MBITS:0]           ld_m_in;
    logic [NBITS:0]           ld_n_in;
    logic [MEM_ADDR_BITS-1:0] ld_mem_base_in;
    logic                     ld_busy_out, ld_done_out, ld_err_out;
    logic                     mem_rd_req_out;
    logic [MEM_ADDR_BITS-1:0] mem_rd_addr_out;
    logic                     mem_rd_valid_in;
    float_sp                  mem_rd_data_in;
    logic                     load_ready_in;
    logic                     reg_load_req_out;
    logic [MATRIX_REG_BITS:0] reg_load_addr_out;
    logic [MBITS:0]           reg_i_load_loc_out, reg_m_load_size_out;
    logic [NBITS:0]           reg_j_load_loc_out, reg_n_load_size_out;
    float_sp                  reg_load_element_out;

    mpu_load_sequencer dut (
        .clk(clk), .rst(rst), .ld_req_in(ld_req_in),
        .ld_reg_addr_in(ld_reg_addr_in), .ld_m_in(ld_m_in), .ld_n_in(ld_n_in),
        .ld_mem_base_in(ld_mem_base_in), .ld_busy_out(ld_busy_out),
        .ld_done_out(ld_done_out), .ld_err_out(ld_err_out),
        .mem_rd_req_out(mem_rd_req_out), .mem_rd_addr_out(mem_rd_addr_out),
        .mem_rd_valid_in(mem_rd_valid_in), .mem_rd_data_in(mem_rd_data_in),
        .load_ready_in(load_ready_in), .reg_load_req_out(reg_load_req_out),
        .reg_load_addr_out(reg_load_addr_out),
        .reg_i_load_loc_out(reg_i_load_loc_out),
        .reg_j_load_loc_out(reg_j_load_loc_out),
        .reg_m_load_size_out(reg_m_load_size_out),
        .reg_n_load_size_out(reg_n_load_size_out),
        .reg_load_element_out(reg_load_element_out)
    );

    always #5 clk = ~clk;

    float_sp                  mem [MEM_SIZE];
    logic [63:0]              exp_wr[$];
    logic [MEM_ADDR_BITS-1:0] exp_rd[$];
    int                       exp_end[$];  // 1 = done, 2 = err

    int checks = 0, errors = 0;
    int mem_lat = 1, ready_mode = 0, stall_elem = -1, stall_len = 0, stall_cnt = 0;
    int wr_idx = 0, busy_cycles = 0;
    bit stray_en = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_wr(input logic [MATRIX_REG_BITS:0] ra,
                                            input logic [MBITS:0] i, input logic [NBITS:0] j,
                                            input logic [MBITS:0] m, input logic [NBITS:0] n,
                                            input float_sp e);
        return 64'({ra, i, j, m, n, e});
    endfunction

    // Memory model: answers each read after mem_lat cycles, optionally
    // injects stray valid pulses while no read is outstanding.
    initial begin
        logic [MEM_ADDR_BITS-1:0] a, e;
        mem_rd_valid_in = 1'b0;
        mem_rd_data_in  = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_req_out && !rst) begin
                a = mem_rd_addr_out;
                if (exp_rd.size() == 0) chk(0, "rd_unexpected", 64'(a), 0);
                else begin
                    e = exp_rd.pop_front();
                    chk(a == e, "rd_addr", 64'(a), 64'(e));
                end
                repeat (mem_lat - 1) @(posedge clk);
                @(posedge clk); #1;
                mem_rd_valid_in = 1'b1;
                mem_rd_data_in  = mem[a];
                @(posedge clk); #1;
                mem_rd_valid_in = 1'b0;
                mem_rd_data_in  = float_sp'($urandom);
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                mem_rd_valid_in = 1'b1;
                mem_rd_data_in  = float_sp'($urandom);
                @(posedge clk); #1;
                mem_rd_valid_in = 1'b0;
            end
        end
    end

    // Register-file side: drives load_ready_in, checks writes, pulses and holds.
    initial begin
        bit r, held, prev_done, prev_err, prev_rd;
        logic [63:0] cur, saved, e;
        held = 0; prev_done = 0; prev_err = 0; prev_rd = 0; saved = '0;
        load_ready_in = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done && ld_done_out) chk(0, "done_width", 1, 0);
            if (prev_err && ld_err_out)   chk(0, "err_width", 1, 0);
            if (prev_rd && mem_rd_req_out) chk(0, "rd_req_width", 1, 0);
            prev_done = ld_done_out; prev_err = ld_err_out; prev_rd = mem_rd_req_out;
            if (ld_done_out) begin
                if (exp_end.size() == 0) chk(0, "done_unexpected", 1, 0);
                else begin
                    e = 64'(exp_end.pop_front());
                    chk(e == 1, "end_kind_done", 1, e);
                end
            end
            if (ld_err_out) begin
                if (exp_end.size() == 0) chk(0, "err_unexpected", 2, 0);
                else begin
                    e = 64'(exp_end.pop_front());
                    chk(e == 2, "end_kind_err", 2, e);
                end
            end
            if (ld_busy_out) busy_cycles++;
            case (ready_mode)
                0: r = 1;
                1: r = ($urandom_range(0, 1) == 1);
                default: begin
                    if (reg_load_req_out && wr_idx == stall_elem && stall_cnt < stall_len) begin
                        r = 0;
                        stall_cnt++;
                    end else r = 1;
                end
            endcase
            load_ready_in = r;
            if (reg_load_req_out) begin
                cur = pack_wr(reg_load_addr_out, reg_i_load_loc_out, reg_j_load_loc_out,
                              reg_m_load_size_out, reg_n_load_size_out, reg_load_element_out);
                if (held) chk(cur == saved, "write_hold_stable", cur, saved);
                if (r) begin
                    if (exp_wr.size() == 0) chk(0, "write_unexpected", cur, 0);
                    else begin
                        e = exp_wr.pop_front();
                        chk(cur == e, "write", cur, e);
                    end
                    wr_idx++;
                    held = 0;
                end else begin
                    saved = cur;
                    held  = 1;
                end
            end else held = 0;
        end
    end

    task automatic push_model(input logic [MATRIX_REG_BITS:0] ra, input logic [MBITS:0] m,
                              input logic [NBITS:0] n, input logic [MEM_ADDR_BITS-1:0] base);
        logic [MEM_ADDR_BITS-1:0] a;
        logic [MBITS:0] iv;
        logic [NBITS:0] jv;
        int t;
        if (m == 0 || n == 0 || int'(m) > M || int'(n) > N) begin
            exp_end.push_back(2);
        end else begin
            for (int i = 0; i < int'(m); i++) begin
                for (int j = 0; j < int'(n); j++) begin
                    t  = int'(base) + i * int'(n) + j;
                    a  = t[MEM_ADDR_BITS-1:0];
                    iv = i[MBITS:0];
                    jv = j[NBITS:0];
                    exp_rd.push_back(a);
                    exp_wr.push_back(pack_wr(ra, iv, jv, m, n, mem[a]));
                end
            end
            exp_end.push_back(1);
        end
    endtask

    task automatic flush();
        exp_wr.delete();
        exp_rd.delete();
        exp_end.delete();
    endtask

    task automatic issue(input logic [MATRIX_REG_BITS:0] ra, input logic [MBITS:0] m,
                         input logic [NBITS:0] n, input logic [MEM_ADDR_BITS-1:0] base);
        @(negedge clk);
        ld_reg_addr_in = ra; ld_m_in = m; ld_n_in = n; ld_mem_base_in = base;
        ld_req_in = 1'b1;
        @(negedge clk);
        ld_req_in      = 1'b0;
        ld_reg_addr_in = 3'($urandom);
        ld_m_in        = 3'($urandom);
        ld_n_in        = 3'($urandom);
        ld_mem_base_in = 12'($urandom);
    endtask

    task automatic run_cmd(input logic [MATRIX_REG_BITS:0] ra, input logic [MBITS:0] m,
                           input logic [NBITS:0] n, input logic [MEM_ADDR_BITS-1:0] base,
                           input int lat, input int rmode, input int selem, input int slen,
                           input bit spam);
        int cyc;
        mem_lat = lat; ready_mode = rmode; stall_elem = selem; stall_len = slen;
        stall_cnt = 0; wr_idx = 0; busy_cycles = 0;
        push_model(ra, m, n, base);
        issue(ra, m, n, base);
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!ld_busy_out) break;
            ld_req_in = spam && ($urandom_range(0, 2) == 0);
        end
        ld_req_in = 1'b0;
        chk(cyc < 3000, "cmd_timeout", 64'(cyc), 3000);
        chk(!ld_busy_out, "busy_after_cmd", 64'(ld_busy_out), 0);
        chk(exp_wr.size() == 0, "writes_remaining", 64'(exp_wr.size()), 0);
        chk(exp_rd.size() == 0, "reads_remaining", 64'(exp_rd.size()), 0);
        chk(exp_end.size() == 0, "end_remaining", 64'(exp_end.size()), 0);
        flush();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk(ld_busy_out == 0, {tag, "_busy"}, 64'(ld_busy_out), 0);
        chk(ld_done_out == 0 && ld_err_out == 0, {tag, "_done_err"}, 64'({ld_done_out, ld_err_out}), 0);
        chk(mem_rd_req_out == 0, {tag, "_rd_req"}, 64'(mem_rd_req_out), 0);
        chk(mem_rd_addr_out == 0, {tag, "_rd_addr"}, 64'(mem_rd_addr_out), 0);
        chk(reg_load_req_out == 0, {tag, "_load_req"}, 64'(reg_load_req_out), 0);
        chk(pack_wr(reg_load_addr_out, reg_i_load_loc_out, reg_j_load_loc_out,
                    reg_m_load_size_out, reg_n_load_size_out, reg_load_element_out) == 0,
            {tag, "_load_fields"},
            pack_wr(reg_load_addr_out, reg_i_load_loc_out, reg_j_load_loc_out,
                    reg_m_load_size_out, reg_n_load_size_out, reg_load_element_out), 0);
    endtask

    initial begin
        int cyc;
        for (int a = 0; a < MEM_SIZE; a++) mem[a] = float_sp'($urandom);
        rst = 1'b1; ld_req_in = 1'b0;
        ld_reg_addr_in = '0; ld_m_in = '0; ld_n_in = '0; ld_mem_base_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2x2 basic with single-cycle memory, ready always high
        run_cmd(3'd1, 3'd2, 3'd2, 12'h100, 1, 0, -1, 0, 0);
        chk(busy_cycles == 13, "latency_2x2", 64'(busy_cycles), 13);

        // 3x1, slow memory, backpressure on second element
        run_cmd(3'd2, 3'd3, 3'd1, 12'h040, 4, 2, 1, 5, 0);
        chk(stall_cnt == 5, "stall_applied", 64'(stall_cnt), 5);
        chk(wr_idx == 3, "write_count_3x1", 64'(wr_idx), 3);

        // size errors
        run_cmd(3'd0, 3'd0, 3'd2, 12'h010, 1, 0, -1, 0, 0);
        chk(busy_cycles == 1, "err_busy_len_m0", 64'(busy_cycles), 1);
        run_cmd(3'd3, 3'd2, 3'(N + 1), 12'h010, 1, 0, -1, 0, 0);
        chk(wr_idx == 0, "err_no_writes", 64'(wr_idx), 0);
        run_cmd(3'd3, 3'(M + 1), 3'd1, 12'h010, 1, 0, -1, 0, 0);

        // spurious commands while busy and stray read-valid pulses
        stray_en = 1;
        run_cmd(3'd5, 3'd2, 3'd3, 12'h200, 2, 1, -1, 0, 1);
        chk(wr_idx == 6, "write_count_spam", 64'(wr_idx), 6);

        // full size with address wrap
        run_cmd(3'd7, 3'(M), 3'(N), 12'(MEM_SIZE - 2), 2, 1, -1, 0, 1);
        chk(wr_idx == M * N, "write_count_full", 64'(wr_idx), 64'(M * N));

        // randomized commands
        for (int k = 0; k < 25; k++) begin
            run_cmd(3'($urandom), 3'($urandom_range(0, M + 1)), 3'($urandom_range(0, N + 1)),
                    12'($urandom), $urandom_range(1, 4), $urandom_range(0, 1), -1, 0,
                    1'($urandom_range(0, 1)));
        end
        stray_en = 0;

        // reset while waiting on element (1,0) of a 2x2
        mem_lat = 3; ready_mode = 0; wr_idx = 0;
        push_model(3'd4, 3'd2, 3'd2, 12'h300);
        issue(3'd4, 3'd2, 3'd2, 12'h300);
        cyc = 0;
        while (!(wr_idx == 2 && mem_rd_req_out) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(cyc < 200, "reach_elem_1_0", 64'(cyc), 200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        flush();
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk(!ld_busy_out, "idle_after_midreset", 64'(ld_busy_out), 0);
        run_cmd(3'd6, 3'd1, 3'd1, 12'h0ff, 1, 0, -1, 0, 0);
        chk(wr_idx == 1, "write_count_after_reset", 64'(wr_idx), 1);
        chk(busy_cycles == 4, "latency_1x1", 64'(busy_cycles), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
